// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor, DIGIT bits per clock over WIDTH/DIGIT cycles.
// Results (s, co, ovf) are loaded only on completion, so partial sums never appear on the outputs.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic               carry_q, carry_d, co_q, co_d, ovf_q, ovf_d, done_q, done_d;
    logic [DIGIT:0]     c;
    logic [DIGIT-1:0]   dsum;
    logic [WIDTH+DIGIT-1:0] acc_full;
    logic               last;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        s_d      = s_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        c        = '0;
        dsum     = '0;
        c[0]     = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1]   = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end
        // new digit enters at the top so the result ends up LSB-aligned after N shifts
        acc_full = {dsum, acc_q};
        last     = (state_q == RUN) && (cnt_q == CW'(N - 1));
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                cnt_d   = '0;
                a_d     = a;
                b_d     = sub ? ~b : b;
                carry_d = sub ? 1'b1 : cin;
            end
        end else begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = c[DIGIT];
            acc_d   = acc_full[WIDTH+DIGIT-1:DIGIT];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
                s_d     = acc_full[WIDTH+DIGIT-1:DIGIT];
                co_d    = c[DIGIT];
                ovf_d   = c[DIGIT] ^ c[DIGIT-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder with DIGIT = 1, 4 and 8 (WIDTH = 8).
module tb_serial_adder;
    logic       clk = 1'b0, rst_n = 1'b0, cin = 1'b0, sub = 1'b0;
    logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy1, done1, co1, ovf1, busy4, done4, co4, ovf4, busy8, done8, co8, ovf8;
    logic [7:0] s1, s4, s8;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
        .cin(cin), .sub(sub), .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1));
    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b),
        .cin(cin), .sub(sub), .busy(busy4), .done(done4), .s(s4), .co(co4), .ovf(ovf4));
    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a), .b(b),
        .cin(cin), .sub(sub), .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int w);
        start1 = (w == 1);
        start4 = (w == 4);
        start8 = (w == 8);
        tick;
        start1 = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_done(input int w, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            n++;
            if ((w == 1 && done1) || (w == 4 && done4) || (w == 8 && done8)) break;
        end
    endtask

    task automatic test_reset;
        tick;
        tick;
        n_chk++;
        if ({busy1, done1, s1, co1, ovf1} !== 12'h000) begin
            n_fail++; $display("FAIL reset_d1: got %h expected 000", {busy1, done1, s1, co1, ovf1});
        end
        n_chk++;
        if ({busy4, done4, s4, co4, ovf4} !== 12'h000) begin
            n_fail++; $display("FAIL reset_d4: got %h expected 000", {busy4, done4, s4, co4, ovf4});
        end
        n_chk++;
        if ({busy8, done8, s8, co8, ovf8} !== 12'h000) begin
            n_fail++; $display("FAIL reset_d8: got %h expected 000", {busy8, done8, s8, co8, ovf8});
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_carry_out;
        int n;
        a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0;
        accept(1);
        n_chk++;
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL carry_busy: got %b expected 1", busy1); end
        wait_done(1, n);
        n_chk++;
        if (n !== 8) begin n_fail++; $display("FAIL carry_latency: got %0d expected 8", n); end
        n_chk++;
        if ({s1, co1, ovf1} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL carry_result: got s=%h co=%b ovf=%b expected s=00 co=1 ovf=0", s1, co1, ovf1);
        end
        tick;
        n_chk++;
        if ({done1, busy1} !== 2'b00) begin n_fail++; $display("FAIL carry_done_pulse: got %b expected 00", {done1, busy1}); end
    endtask

    task automatic test_overflow;
        int n;
        a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0;
        accept(1);
        tick;
        tick;
        wait_done(1, n);
        n_chk++;
        if (n + 2 !== 8) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 8", n + 2); end
        n_chk++;
        if ({s1, co1, ovf1} !== {8'h80, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ovf_result: got s=%h co=%b ovf=%b expected s=80 co=0 ovf=1", s1, co1, ovf1);
        end
        a = 8'h05; b = 8'h07; cin = 1'b1; sub = 1'b1;
        accept(1);
        a = 8'hAA; b = 8'h33; cin = 1'b0; sub = 1'b0;
        tick;
        tick;
        tick;
        n_chk++;
        if ({s1, co1, ovf1} !== {8'h80, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL sub_hold: got s=%h co=%b ovf=%b expected s=80 co=0 ovf=1", s1, co1, ovf1);
        end
        wait_done(1, n);
        n_chk++;
        if (n + 3 !== 8) begin n_fail++; $display("FAIL sub_latency: got %0d expected 8", n + 3); end
        n_chk++;
        if ({s1, co1, ovf1} !== {8'hFE, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL sub_result: got s=%h co=%b ovf=%b expected s=fe co=0 ovf=0", s1, co1, ovf1);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        a = 8'h3C; b = 8'h0F; cin = 1'b1; sub = 1'b0;
        accept(4);
        wait_done(4, n);
        n_chk++;
        if (n !== 2) begin n_fail++; $display("FAIL d4_latency: got %0d expected 2", n); end
        n_chk++;
        if ({s4, co4, ovf4} !== {8'h4C, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL d4_result: got s=%h co=%b ovf=%b expected s=4c co=0 ovf=0", s4, co4, ovf4);
        end
        a = 8'h80; b = 8'h80; cin = 1'b0;
        accept(4);
        n_chk++;
        if ({done4, busy4} !== 2'b01) begin n_fail++; $display("FAIL b2b_accept: got %b expected 01", {done4, busy4}); end
        wait_done(4, n);
        n_chk++;
        if (n !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 2", n); end
        n_chk++;
        if ({s4, co4, ovf4} !== {8'h00, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL b2b_result: got s=%h co=%b ovf=%b expected s=00 co=1 ovf=1", s4, co4, ovf4);
        end
        tick;
        n_chk++;
        if (done4 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_fall: got %b expected 0", done4); end
    endtask

    task automatic test_single_digit;
        a = 8'hC8; b = 8'h64; cin = 1'b0; sub = 1'b0;
        accept(8);
        n_chk++;
        if ({busy8, done8} !== 2'b10) begin n_fail++; $display("FAIL d8_accept: got %b expected 10", {busy8, done8}); end
        tick;
        n_chk++;
        if ({busy8, done8} !== 2'b01) begin n_fail++; $display("FAIL d8_done: got %b expected 01", {busy8, done8}); end
        n_chk++;
        if ({s8, co8, ovf8} !== {8'h2C, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL d8_result: got s=%h co=%b ovf=%b expected s=2c co=1 ovf=0", s8, co8, ovf8);
        end
        tick;
        n_chk++;
        if (done8 !== 1'b0) begin n_fail++; $display("FAIL d8_done_fall: got %b expected 0", done8); end
    endtask

    task automatic test_start_ignored;
        int ndone = 0;
        logic [9:0] res = '0;
        a = 8'h21; b = 8'h43; cin = 1'b0; sub = 1'b0;
        accept(1);
        tick;
        tick;
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        if (done1) begin ndone++; res = {s1, co1, ovf1}; end
        for (int i = 0; i < 14; i++) begin
            tick;
            if (done1) begin ndone++; res = {s1, co1, ovf1}; end
        end
        n_chk++;
        if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        n_chk++;
        if (res !== {8'h64, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", res, {8'h64, 2'b00}); end
    endtask

    task automatic test_reset_abort;
        int n, ndone = 0;
        a = 8'h55; b = 8'h11; cin = 1'b0; sub = 1'b0;
        accept(1);
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy1, done1, s1, co1, ovf1} !== 12'h000) begin
            n_fail++; $display("FAIL abort_d1: got %h expected 000", {busy1, done1, s1, co1, ovf1});
        end
        n_chk++;
        if ({busy4, done4, s4, co4, ovf4, busy8, done8, s8, co8, ovf8} !== 24'h0) begin
            n_fail++; $display("FAIL abort_d4_d8: got %h expected 000000", {busy4, done4, s4, co4, ovf4, busy8, done8, s8, co8, ovf8});
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done1) ndone++;
        end
        n_chk++;
        if ({ndone, busy1} !== {32'd0, 1'b0}) begin n_fail++; $display("FAIL abort_no_done: got done=%0d busy=%b expected 0 0", ndone, busy1); end
        a = 8'h12; b = 8'h34;
        accept(1);
        wait_done(1, n);
        n_chk++;
        if (n !== 8) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 8", n); end
        n_chk++;
        if ({s1, co1, ovf1} !== {8'h46, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL post_reset_result: got s=%h co=%b ovf=%b expected s=46 co=0 ovf=0", s1, co1, ovf1);
        end
    endtask

    initial begin
        test_reset;
        test_carry_out;
        test_overflow;
        test_back_to_back;
        test_single_digit;
        test_start_ignored;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001: Parameter WIDTH, default 8, operand and result width in bits; legal values are 2 or more.
REQ-002: Parameter DIGIT, default 1, bits summed per clock; legal values are 1 to WIDTH, and WIDTH SHALL be a multiple of DIGIT.
REQ-003: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: start  input  1  request a new operation; sampled on each rising edge.
REQ-006: a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-007: b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-008: cin  input  1  carry-in; sampled only when start is accepted; ignored when sub=1.
REQ-009: sub  input  1  mode select, sampled only when start is accepted: 0 computes a+b+cin, 1 computes a-b.
REQ-010: busy  output  1  high while an operation is in progress.
REQ-011: done  output  1  one-cycle pulse marking that s, co and ovf have been updated.
REQ-012: s  output  WIDTH  registered sum or difference.
REQ-013: co  output  1  registered carry-out of the MSB; for sub=1 this is the not-borrow value.
REQ-014: ovf  output  1  registered two's-complement overflow, defined as carry into the MSB XOR carry out of the MSB.

Function
REQ-015: The block SHALL use an FSM with states IDLE and RUN, plus an internal digit counter of clog2(N) bits, where N = WIDTH/DIGIT.
REQ-016: Start acceptance: start=1 with busy=0 at an edge SHALL accept the request, latch a, b (inverted if sub=1), and carry (1 if sub=1, otherwise cin), clear the counter, and move to RUN.
REQ-017: start=1 while busy=1 SHALL be ignored, with no effect on operands, counter or result.
REQ-018: Each edge in RUN SHALL add the lowest DIGIT bits of the working operands plus the carry through a DIGIT-bit full-adder chain, shift the DIGIT sum bits into the result register LSB-first, register the carry-out, and increment the counter.
REQ-019: On the edge that processes the last digit (counter = N-1), the block SHALL load s, co and ovf together, set done=1, set busy=0, and return to IDLE.
REQ-020: Latency SHALL be exactly N edges from the accepting edge to the edge at which done rises.
REQ-021: s, co and ovf SHALL hold their values between completions; intermediate digits SHALL never be visible on these outputs.
REQ-022: done SHALL be high for exactly one cycle per completed operation.
REQ-023: start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back operations; done SHALL still fall after one cycle.
REQ-024: Changes on a, b, cin and sub while busy=1 SHALL NOT affect the operation in progress.
REQ-025: With DIGIT=WIDTH (N=1), the block SHALL complete in one cycle, with busy high for exactly one cycle.

Reset
REQ-026: rst_n=0 SHALL immediately force the state to IDLE, counter=0, busy=0, done=0, s=0, co=0 and ovf=0, independent of clk.
REQ-027: Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-028: The first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-029: WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0, sub=0 -> s=8'h00, co=1, ovf=0, done exactly 8 edges after the accepting edge.
REQ-030: WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, cin=0 -> s=8'h80, co=0, ovf=1; then sub=1, a=8'h05, b=8'h07 -> s=8'hFE, co=0, ovf=0.
REQ-031: WIDTH=8, DIGIT=4: a=8'h3C, b=8'h0F, cin=1 -> s=8'h4C, co=0, done 2 edges after acceptance; then start held in the done cycle with a=8'h80, b=8'h80 -> s=8'h00, co=1, ovf=1, 2 edges later.
REQ-032: Start pulsed with new operands at cycle 3 of a running operation -> that start is ignored, the original result is delivered, and exactly one done pulse occurs.
REQ-033: rst_n pulsed low at cycle 4 of an operation -> all outputs are 0 immediately, no done pulse follows, and the next start completes correctly (a=8'h12, b=8'h34 -> s=8'h46).
